// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_if_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  // Width of a word index into a DEPTH-entry array.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_sp_32.sv
// Single-port 32-bit word array: synchronous write, registered read.
module sram_sp_32
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IdxW = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IdxW-1:0]   addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents and read register are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states,
// one access cycle, then a held response with in-band error.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // Load value unused when WAIT_CYCLES is 0 (WAIT is skipped).
  localparam logic [CntW-1:0] CntInit = CntW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              rdata_sel_q;

  logic              accept;
  logic              access_err;
  logic              in_access;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign accept     = req_valid & req_ready;
  assign in_access  = (state_q == StAccess);
  // DEPTH is a power of two, so out-of-range means any bit above the index is set.
  assign access_err = (addr_q[1:0] != 2'b00) | (addr_q[DATA_W-1:IdxW+2] != '0);
  assign mem_we     = in_access & we_q & ~access_err;
  assign mem_re     = in_access & ~we_q & ~access_err;

  sram_sp_32 #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q[IdxW+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request capture: inputs are only looked at on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response flags: set on the access edge, valid cleared on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_sel_q  <= 1'b0;
    end else if (in_access) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= access_err;
      rdata_sel_q  <= ~we_q & ~access_err;
    end else if ((state_q == StResp) && resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Outputs; read data is forced to zero for stores, errors and after reset.
  always_comb begin
    req_ready  = rst_n & (state_q == StIdle);
    resp_valid = resp_valid_q;
    resp_err   = resp_err_q;
    resp_rdata = rdata_sel_q ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: drivers push expected responses, monitors pop and compare.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAIT  = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];
  int rr_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  function automatic logic is_err(input logic [31:0] addr);
    return ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
  endfunction

  // Issue one request to the WAIT=2 instance; optionally record its expectation.
  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit track);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!a_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) begin
      fail_now("a_req_ready_wait");
      return;
    end
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom);
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
    if (track) begin
      e.err   = is_err(addr);
      e.acc   = cyc;
      e.rdata = (we || e.err) ? 32'h0 : mdl_a[addr / 4];
      if (we && !e.err) mdl_a[addr / 4] = wdata;
      qa.push_back(e);
    end
  endtask

  int unsigned b_last_acc;
  bit          b_have_last = 0;

  // Issue to the WAIT=0 instance and check the issue interval.
  task automatic issue_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!b_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_req_ready) begin
      fail_now("b_req_ready_wait");
      return;
    end
    b_req_valid = 1'b1;
    b_req_we    = we;
    b_req_addr  = addr;
    b_req_wdata = wdata;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    b_req_addr  = $urandom;
    b_req_wdata = $urandom;
    if (b_have_last) check("b_issue_interval", 32'(cyc - b_last_acc), 32'd3);
    b_last_acc  = cyc;
    b_have_last = 1;
    e.err   = is_err(addr);
    e.acc   = cyc;
    e.rdata = (we || e.err) ? 32'h0 : mdl_b[addr / 4];
    if (we && !e.err) mdl_b[addr / 4] = wdata;
    qb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_resp_valid || b_resp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain");
  endtask

  // resp_ready driver for the WAIT=2 instance, updated just after each rising edge.
  initial begin
    a_resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_resp_ready = (rr_mode == 0) ? ($urandom_range(0, 2) != 0) : (rr_mode == 2);
    end
  end

  // Monitor A: compare on first presentation, then check stability while held.
  exp_t a_cur;
  bit   a_prev = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev = 0;
    end else if (a_resp_valid) begin
      if (!a_prev) begin
        if (qa.size() == 0) begin
          fail_now("a_unexpected_resp");
          a_cur.rdata = 'x;
          a_cur.err   = 'x;
        end else begin
          a_cur = qa.pop_front();
          check("a_latency", 32'(cyc - a_cur.acc), 32'(1 + WAIT));
        end
      end
      check("a_rdata", a_resp_rdata, a_cur.rdata);
      check("a_err", 32'(a_resp_err), 32'(a_cur.err));
      check("a_req_ready_busy", 32'(a_req_ready), 32'd0);
      a_prev = !a_resp_ready;
    end else begin
      a_prev = 0;
    end
  end

  // Monitor B: resp_ready is held high, so every valid cycle is a new response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_resp_valid) begin
      if (qb.size() == 0) begin
        fail_now("b_unexpected_resp");
      end else begin
        e = qb.pop_front();
        check("b_latency", 32'(cyc - e.acc), 32'd1);
        check("b_rdata", b_resp_rdata, e.rdata);
        check("b_err", 32'(b_resp_err), 32'(e.err));
        check("b_req_ready_busy", 32'(b_req_ready), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          sel;
    int          n;

    rst_n = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0;
    b_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_resp_rdata", a_resp_rdata, 32'd0);
    check("rst_resp_err", 32'(a_resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(a_req_ready), 32'd1);

    // Fill every word so later random loads have known contents.
    for (int i = 0; i < DEPTH; i++) issue_a(1'b1, 32'(i * 4), $urandom, 1);

    // Directed store/load, misaligned and out-of-range cases.
    issue_a(1'b1, 32'h08, 32'hDEADBEEF, 1);
    issue_a(1'b0, 32'h08, 32'h0, 1);
    issue_a(1'b1, 32'h0A, 32'h1234, 1);
    issue_a(1'b0, 32'h08, 32'h0, 1);
    issue_a(1'b0, 32'h100, 32'h0, 1);
    issue_a(1'b0, 32'h00, 32'h0, 1);
    issue_a(1'b0, 32'hFC, 32'h0, 1);
    issue_a(1'b1, 32'h100, 32'hCAFEF00D, 1);
    issue_a(1'b0, 32'hFC, 32'h0, 1);
    drain();

    // Backpressure: hold resp_ready low for five cycles after resp_valid.
    rr_mode = 1;
    @(posedge clk);
    issue_a(1'b0, 32'h08, 32'h0, 1);
    n = 0;
    while (!a_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!a_resp_valid) fail_now("bp_resp_valid_wait");
    repeat (5) @(negedge clk);
    check("bp_still_valid", 32'(a_resp_valid), 32'd1);
    rr_mode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_req_ready_after", 32'(a_req_ready), 32'd1);
    check("bp_valid_dropped", 32'(a_resp_valid), 32'd0);

    // Randomized mix with random backpressure.
    rr_mode = 0;
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel == 7) addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = ($urandom | 32'h100) & 32'hFFFF_FFFC;
      else               addr = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'hFC;
      issue_a(1'($urandom), addr, $urandom, 1);
    end
    rr_mode = 2;
    drain();

    // Reset during WAIT discards the pending store.
    issue_a(1'b1, 32'h10, 32'h11111111, 1);
    drain();
    issue_a(1'b1, 32'h10, 32'hA5A5A5A5, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(a_req_ready), 32'd0);
    check("mid_rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("mid_rst_resp_rdata", a_resp_rdata, 32'd0);
    check("mid_rst_resp_err", 32'(a_resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(a_req_ready), 32'd1);
    issue_a(1'b0, 32'h10, 32'h0, 1);
    drain();

    // WAIT_CYCLES=0 instance: back-to-back every three cycles.
    for (int i = 0; i < 8; i++) issue_b(1'b1, 32'(i * 4), $urandom);
    issue_b(1'b0, 32'h06, 32'h0);
    issue_b(1'b1, 32'h200, 32'h5555AAAA);
    for (int i = 0; i < 8; i++) issue_b(1'b0, 32'(i * 4), 32'h0);
    for (int i = 0; i < 20; i++) begin
      addr = 32'($urandom_range(0, 7)) * 4 + (($urandom_range(0, 4) == 0) ? 32'h2 : 32'h0);
      issue_b(1'($urandom), addr, $urandom);
    end
    drain();

    check("final_qa_empty", 32'(qa.size()), 32'd0);
    check("final_qb_empty", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
